traffic_sensor: RTL and testbench

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

---
 rtl/traffic_sensor_pkg.sv | 30 +++
 rtl/traffic_sensor_queue.sv | 68 ++++++
 rtl/traffic_sensor.sv | 96 +++++++++
 tb/tb_traffic_sensor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_sensor_pkg.sv
// Shared light encodings, violation codes and the light-transition rule
// used by the traffic sensor and its per-street queues.
package traffic_sensor_pkg;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;
    localparam logic [1:0] LIGHT_BAD    = 2'b11;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_BAD_ENC   = 2'b01;
    localparam logic [1:0] ERR_CONFLICT  = 2'b10;
    localparam logic [1:0] ERR_BAD_TRANS = 2'b11;

    // Departure timer width; covers DEPART_CYC up to 15.
    localparam int TIMER_W = 4;

    // A light may hold its value or advance one step around G->Y->R->G.
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        case (prev)
            LIGHT_GREEN:  ok = (cur == LIGHT_GREEN)  || (cur == LIGHT_YELLOW);
            LIGHT_YELLOW: ok = (cur == LIGHT_YELLOW) || (cur == LIGHT_RED);
            LIGHT_RED:    ok = (cur == LIGHT_RED)    || (cur == LIGHT_GREEN);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_sensor_queue.sv
// One street: saturating car counter, departure timer while green,
// one-cycle drop pulse on overflow and a registered traffic-present flag.
module traffic_queue
    import traffic_sensor_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive,
    input  logic [1:0]    light,
    output logic [QW-1:0] q,
    output logic          t,
    output logic          drop
);

    localparam logic [QW-1:0]      Q_MAX  = '1;
    localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(DEPART_CYC - 1);

    logic [QW-1:0]      count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               drop_q, drop_d;
    logic               green;
    logic               full;
    logic               depart;

    always_comb begin
        green   = (light == LIGHT_GREEN);
        full    = (count_q == Q_MAX);
        depart  = green && (timer_q == T_LAST) && (count_q != '0);
        timer_d = '0;
        count_d = count_q;
        drop_d  = 1'b0;

        if (green && (timer_q != T_LAST)) begin
            timer_d = timer_q + 1'b1;
        end

        // Arrival and departure together cancel, even at full count.
        if (arrive && !depart) begin
            if (full) begin
                drop_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (depart && !arrive) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            timer_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
        end
    end

    assign q    = count_q;
    assign t    = (count_q != '0);
    assign drop = drop_q;

endmodule

// File: rtl/traffic_sensor.sv
// Two-street traffic sensor: per-street car queues plus a sticky checker
// that latches the first light-protocol violation it sees.
module traffic_sensor
    import traffic_sensor_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_a,
    input  logic          arrive_b,
    input  logic [1:0]    LA,
    input  logic [1:0]    LB,
    output logic          TA,
    output logic          TB,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          drop_a,
    output logic          drop_b,
    output logic          err,
    output logic [1:0]    err_code
);

    traffic_queue #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_queue_a (
        .clk    (clk),
        .reset  (reset),
        .arrive (arrive_a),
        .light  (LA),
        .q      (qa),
        .t      (TA),
        .drop   (drop_a)
    );

    traffic_queue #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_queue_b (
        .clk    (clk),
        .reset  (reset),
        .arrive (arrive_b),
        .light  (LB),
        .q      (qb),
        .t      (TB),
        .drop   (drop_b)
    );

    logic [1:0] prev_la_q, prev_la_d;
    logic [1:0] prev_lb_q, prev_lb_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic       bad_enc;
    logic       conflict;
    logic       bad_trans;
    logic [1:0] viol_code;

    always_comb begin
        prev_la_d  = LA;
        prev_lb_d  = LB;
        bad_enc    = (LA == LIGHT_BAD) || (LB == LIGHT_BAD);
        conflict   = (LA != LIGHT_RED) && (LB != LIGHT_RED);
        bad_trans  = !legal_step(prev_la_q, LA) || !legal_step(prev_lb_q, LB);
        viol_code  = ERR_NONE;
        err_d      = err_q;
        err_code_d = err_code_q;

        if (bad_enc) begin
            viol_code = ERR_BAD_ENC;
        end else if (conflict) begin
            viol_code = ERR_CONFLICT;
        end else if (bad_trans) begin
            viol_code = ERR_BAD_TRANS;
        end

        // Only the first violation is recorded; the flag then sticks until reset.
        if (!err_q && (viol_code != ERR_NONE)) begin
            err_d      = 1'b1;
            err_code_d = viol_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_la_q  <= LIGHT_GREEN;
            prev_lb_q  <= LIGHT_RED;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            prev_la_q  <= prev_la_d;
            prev_lb_q  <= prev_lb_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_traffic_sensor.sv
// Bench for traffic_sensor: directed scenarios plus randomized light and
// arrival traffic, all checked cycle by cycle against a behavioural model.
module tb_traffic_sensor;

    localparam int QW         = 4;
    localparam int DEPART_CYC = 3;
    localparam int MAXQ       = (1 << QW) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          reset;
    logic          arrive_a;
    logic          arrive_b;
    logic [1:0]    la;
    logic [1:0]    lb;
    logic          ta;
    logic          tb_o;
    logic [QW-1:0] qa;
    logic [QW-1:0] qb;
    logic          drop_a;
    logic          drop_b;
    logic          err;
    logic [1:0]    err_code;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    traffic_sensor #(.QW(QW), .DEPART_CYC(DEPART_CYC)) dut (
        .clk      (clk),
        .reset    (reset),
        .arrive_a (arrive_a),
        .arrive_b (arrive_b),
        .LA       (la),
        .LB       (lb),
        .TA       (ta),
        .TB       (tb_o),
        .qa       (qa),
        .qb       (qb),
        .drop_a   (drop_a),
        .drop_b   (drop_b),
        .err      (err),
        .err_code (err_code)
    );

    // ---------------- scoreboard counters / check ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [QW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Counts are plain integers clamped to 0..MAXQ; timers count modulo DEPART_CYC.
    int m_q[2];
    int m_t[2];
    int m_drop[2];
    int m_prev[2];
    int m_err;
    int m_code;
    int nxt_light[3] = '{1, 2, 0};

    function automatic bit light_ok(input int prev, input int cur);
        if (cur == prev) return 1'b1;
        if (prev > 2) return 1'b0;
        return cur == nxt_light[prev];
    endfunction

    function automatic void model_step();
        int lt[2];
        int arr[2];
        int dep;
        int sum;
        int code;
        lt[0]  = int'(la);
        lt[1]  = int'(lb);
        arr[0] = int'(arrive_a);
        arr[1] = int'(arrive_b);
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                m_q[s]    = 0;
                m_t[s]    = 0;
                m_drop[s] = 0;
            end
            m_prev[0] = 0;
            m_prev[1] = 2;
            m_err     = 0;
            m_code    = 0;
            return;
        end
        for (int s = 0; s < 2; s++) begin
            dep       = (lt[s] == 0 && m_t[s] == DEPART_CYC - 1 && m_q[s] > 0) ? 1 : 0;
            sum       = m_q[s] + arr[s] - dep;
            m_drop[s] = (sum > MAXQ) ? 1 : 0;
            m_q[s]    = (sum > MAXQ) ? MAXQ : sum;
            m_t[s]    = (lt[s] == 0) ? (m_t[s] + 1) % DEPART_CYC : 0;
        end
        code = 0;
        if (lt[0] == 3 || lt[1] == 3) code = 1;
        else if (lt[0] != 2 && lt[1] != 2) code = 2;
        else if (!light_ok(m_prev[0], lt[0]) || !light_ok(m_prev[1], lt[1])) code = 3;
        if (m_err == 0 && code != 0) begin
            m_err  = 1;
            m_code = code;
        end
        m_prev[0] = lt[0];
        m_prev[1] = lt[1];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("qa", 32'(qa), 32'(m_q[0]));
        check("qb", 32'(qb), 32'(m_q[1]));
        check("ta", 32'(ta), 32'(m_q[0] != 0));
        check("tb", 32'(tb_o), 32'(m_q[1] != 0));
        check("drop_a", 32'(drop_a), 32'(m_drop[0]));
        check("drop_b", 32'(drop_b), 32'(m_drop[1]));
        check("err", 32'(err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
    endtask

    task automatic pulse_a();
        arrive_a = 1'b1;
        tick();
        arrive_a = 1'b0;
        tick();
    endtask

    task automatic random_segment(input int mode);
        int phase;
        int left;
        reset    = 1'b0;
        la       = 2'b00;
        lb       = 2'b10;
        arrive_a = 1'($urandom_range(0, 1));
        arrive_b = 1'($urandom_range(0, 1));
        tick();
        tick();
        reset = 1'b1;
        phase = 0;
        left  = $urandom_range(1, 12);
        for (int c = 0; c < 400; c++) begin
            arrive_a = ($urandom_range(0, 9) < 4);
            arrive_b = ($urandom_range(0, 9) < 4);
            if (mode == 0) begin
                // Well-behaved controller cycling both streets.
                left--;
                if (left == 0) begin
                    phase = (phase + 1) % 4;
                    left  = $urandom_range(1, 12);
                end
                case (phase)
                    0: begin la = 2'b00; lb = 2'b10; end
                    1: begin la = 2'b01; lb = 2'b10; end
                    2: begin la = 2'b10; lb = 2'b00; end
                    default: begin la = 2'b10; lb = 2'b01; end
                endcase
            end else begin
                if ($urandom_range(0, 15) == 0) la = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) lb = 2'($urandom_range(0, 3));
                reset = ($urandom_range(0, 99) != 0);
            end
            tick();
        end
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [QW-1:0] e;
        reset    = 1'b0;
        arrive_a = 1'b1;
        arrive_b = 1'b1;
        la       = 2'b00;
        lb       = 2'b10;
        tick();
        tick();
        check("rst_qa", 32'(qa), 0);
        check("rst_qb", 32'(qb), 0);
        check("rst_ta", 32'(ta), 0);
        check("rst_tb", 32'(tb_o), 0);
        check("rst_err", 32'(err), 0);
        check("rst_code", 32'(err_code), 0);

        reset    = 1'b1;
        arrive_a = 1'b0;
        arrive_b = 1'b0;
        tick();
        check("post_rst_ta", 32'(ta), 0);

        // Walk A to red legally, then queue three cars.
        la = 2'b01;
        tick();
        la = 2'b10;
        tick();
        for (int k = 1; k <= 3; k++) begin
            arrive_a = 1'b1;
            tick();
            check("arr_qa", 32'(qa), 32'(k));
            check("arr_ta", 32'(ta), 1);
            arrive_a = 1'b0;
            tick();
            check("arr_hold_qa", 32'(qa), 32'(k));
        end

        // Green on A drains one car every third edge.
        exp_q = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
        la = 2'b00;
        for (int i = 0; i < 9; i++) begin
            tick();
            e = exp_q.pop_front();
            check("dep_qa", 32'(qa), 32'(e));
            check("dep_err", 32'(err), 0);
        end
        check("dep_ta", 32'(ta), 0);

        // Saturate B; only the 16th car is dropped.
        for (int k = 1; k <= 16; k++) begin
            arrive_b = 1'b1;
            tick();
            check("sat_drop", 32'(drop_b), 32'(k == 16));
            arrive_b = 1'b0;
            tick();
            check("sat_drop_clr", 32'(drop_b), 0);
        end
        check("sat_qb", 32'(qb), 15);

        // Arrival on the departure edge leaves the count unchanged.
        la = 2'b01;
        tick();
        la = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) pulse_a();
        check("sim_pre_qa", 32'(qa), 5);
        la = 2'b00;
        tick();
        tick();
        arrive_a = 1'b1;
        tick();
        arrive_a = 1'b0;
        check("sim_qa", 32'(qa), 5);
        check("sim_drop", 32'(drop_a), 0);

        // Conflict latches code 10; a later bad encoding is ignored.
        lb = 2'b01;
        tick();
        check("conf_err", 32'(err), 1);
        check("conf_code", 32'(err_code), 2);
        la = 2'b11;
        tick();
        check("conf_sticky", 32'(err_code), 2);

        // Reset while violating, then green->red on A is an illegal transition.
        reset = 1'b0;
        la    = 2'b10;
        lb    = 2'b10;
        tick();
        tick();
        check("viol_rst_err", 32'(err), 0);
        reset = 1'b1;
        tick();
        check("trans_err", 32'(err), 1);
        check("trans_code", 32'(err_code), 3);
        la = 2'b01;
        tick();
        check("trans_sticky", 32'(err_code), 3);

        for (int seg = 0; seg < 6; seg++) random_segment(seg % 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
